// File: rtl/des_dec_key_sched_if.sv
// des_dec_key_sched_if: key-schedule control and subkey handshake bundle.
// With DES_KS_ENC_MODE_EN defined an enc mode select is added.
interface des_dec_key_sched_if;
    logic        start;
    logic        abort;
    logic [55:0] key_cd;
    logic        sub_ready;
    logic        sub_valid;
    logic [47:0] subkey;
    logic [55:0] sub_cd;
    logic [3:0]  round;
    logic        last;
    logic        busy;
`ifdef DES_KS_ENC_MODE_EN
    logic        enc;
    modport master (
        output start, abort, key_cd, sub_ready, enc,
        input  sub_valid, subkey, sub_cd, round, last, busy
    );
    modport slave (
        input  start, abort, key_cd, sub_ready, enc,
        output sub_valid, subkey, sub_cd, round, last, busy
    );
`else
    modport master (
        output start, abort, key_cd, sub_ready,
        input  sub_valid, subkey, sub_cd, round, last, busy
    );
    modport slave (
        input  start, abort, key_cd, sub_ready,
        output sub_valid, subkey, sub_cd, round, last, busy
    );
`endif
endinterface

// File: rtl/des_dec_key_sched.sv
// des_dec_key_sched: sequential DES key schedule emitting K16..K1 over valid/ready.
// Define DES_KS_ENC_MODE_EN to add an enc select (left rotate, K1..K16 order).
module des_dec_key_sched (
    input logic                  clk,
    input logic                  rst_n,
    des_dec_key_sched_if.slave   ks
);
    typedef enum logic {IDLE, HOLD} state_t;

    localparam int pc2_tab [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state, state_n;
    logic [55:0] cd, cd_n, cd_load, cd_adv;
    logic [3:0]  rnd, rnd_n, rnd_inc;

    function automatic logic [1:0] amt_dec(input logic [3:0] r);
        return (r == 4'd0) ? 2'd0 :
               (r == 4'd1 || r == 4'd8 || r == 4'd15) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] a);
        return (a == 2'd1) ? {x[0], x[27:1]} :
               (a == 2'd2) ? {x[1:0], x[27:2]} : x;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-pc2_tab[i]];
        return y;
    endfunction

`ifdef DES_KS_ENC_MODE_EN
    logic enc_q;

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] a);
        return (a == 2'd1) ? {x[26:0], x[27]} :
               (a == 2'd2) ? {x[25:0], x[27:26]} : x;
    endfunction

    function automatic logic [55:0] step(input logic [55:0] x, input logic [3:0] r,
                                         input logic e);
        logic [1:0] a;
        a = e ? ((r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15) ? 2'd1 : 2'd2)
              : amt_dec(r);
        return e ? {rotl(x[55:28], a), rotl(x[27:0], a)}
                 : {rotr(x[55:28], a), rotr(x[27:0], a)};
    endfunction

    // the load uses the live enc input; later rounds use the captured mode
    assign cd_load = step(ks.key_cd, 4'd0, ks.enc);
    assign cd_adv  = step(cd, rnd_inc, enc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            enc_q <= 1'b0;
        else if (state == IDLE && ks.start && !ks.abort)
            enc_q <= ks.enc;
    end
`else
    function automatic logic [55:0] step(input logic [55:0] x, input logic [3:0] r);
        return {rotr(x[55:28], amt_dec(r)), rotr(x[27:0], amt_dec(r))};
    endfunction

    assign cd_load = step(ks.key_cd, 4'd0);
    assign cd_adv  = step(cd, rnd_inc);
`endif

    assign rnd_inc = rnd + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cd    <= '0;
            rnd   <= '0;
        end else begin
            state <= state_n;
            cd    <= cd_n;
            rnd   <= rnd_n;
        end
    end

    // abort outranks both start and a completing handshake
    always_comb begin
        state_n = state;
        cd_n    = cd;
        rnd_n   = rnd;
        if (ks.abort) begin
            state_n = IDLE;
            rnd_n   = (state == HOLD) ? 4'd0 : rnd;
        end else if (state == IDLE) begin
            if (ks.start) begin
                state_n = HOLD;
                cd_n    = cd_load;
                rnd_n   = 4'd0;
            end
        end else if (ks.sub_ready) begin
            state_n = (rnd == 4'd15) ? IDLE : HOLD;
            cd_n    = (rnd == 4'd15) ? cd : cd_adv;
            rnd_n   = (rnd == 4'd15) ? rnd : rnd_inc;
        end
    end

    assign ks.sub_valid = (state == HOLD);
    assign ks.busy      = (state != IDLE);
    assign ks.last      = (state == HOLD) && (rnd == 4'd15);
    assign ks.round     = rnd;
    assign ks.sub_cd    = cd;
    assign ks.subkey    = pc2(cd);
endmodule

// File: tb/tb_des_dec_key_sched.sv
// tb_des_dec_key_sched: directed checks of the DES key schedule, expected halves
// derived from cumulative left-shift counts and an independent PC-1/PC-2 model.
module tb_des_dec_key_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   fails = 0;
    int   total = 0;
    logic [55:0] key1;
    logic [55:0] key2;

    always #5 clk = ~clk;

    des_dec_key_sched_if ks();
    des_dec_key_sched dut (.clk(clk), .rst_n(rst_n), .ks(ks));

    localparam int pc1_tab [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int pc2_tab [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = k[64-pc1_tab[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-pc2_tab[i]];
        return y;
    endfunction

    // total FIPS left shifts applied through encryption round n
    function automatic int cum(input int n);
        int s;
        s = 0;
        for (int i = 1; i <= n; i++) s += (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
        return s;
    endfunction

    function automatic logic [27:0] rol(input logic [27:0] x, input int n);
        logic [55:0] d;
        d = {x, x} << n;
        return d[55:28];
    endfunction

    // decryption output r is K(16-r); encryption output r is K(r+1)
    function automatic logic [55:0] exp_cd(input logic [55:0] k, input int r, input logic e);
        int n;
        n = e ? cum(r + 1) : cum(16 - r);
        return {rol(k[55:28], n), rol(k[27:0], n)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [55:0] k, input logic e, input int stall_r,
                       input int poke_r, input int abort_r, input int rst_r);
        int r, stalls, xfers;
        logic [55:0] ecd;
        r = 0;
        stalls = 0;
        xfers = 0;
        ks.key_cd = k;
        ks.start = 1'b1;
        ks.abort = 1'b0;
        ks.sub_ready = 1'b1;
`ifdef DES_KS_ENC_MODE_EN
        ks.enc = e;
`endif
        tick();
        ks.start = 1'b0;
        for (int cyc = 0; cyc < 40 && r < 16; cyc++) begin
            ecd = exp_cd(k, r, e);
            chk("valid", 64'(ks.sub_valid), 64'(1));
            chk("busy", 64'(ks.busy), 64'(1));
            chk("round", 64'(ks.round), 64'(r));
            chk("sub_cd", 64'(ks.sub_cd), 64'(ecd));
            chk("subkey", 64'(ks.subkey), 64'(pc2(ecd)));
            chk("last", 64'(ks.last), 64'(r == 15));
            if (k == key1 && !e && (r == 0 || r == 1 || r == 2 || r == 15))
                chk("t1_c", 64'(ks.sub_cd[55:28]), 64'(r == 0 ? 28'h0000001 : r == 1 ? 28'h8000000 :
                                                       r == 2 ? 28'h2000000 : 28'h0000002));
            if (k == key1 && !e && r == 15)
                chk("t1_d", 64'(ks.sub_cd[27:0]), 64'(28'h0000002));
            if (k == key1 && e && (r == 0 || r == 15))
                chk("enc_c", 64'(ks.sub_cd[55:28]), 64'(r == 0 ? 28'h0000002 : 28'h0000001));
            if (k == key2 && (r == 0 || r == 15))
                chk("fips_subkey", 64'(ks.subkey),
                    64'(((r == 0) ^ e) ? 48'hCB3D8B0E17F5 : 48'h1B02EFFC7072));
            if (r == rst_r) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_valid", 64'(ks.sub_valid), 64'(0));
                chk("rst_busy", 64'(ks.busy), 64'(0));
                chk("rst_last", 64'(ks.last), 64'(0));
                chk("rst_round", 64'(ks.round), 64'(0));
                chk("rst_cd", 64'(ks.sub_cd), 64'(0));
                chk("rst_subkey", 64'(ks.subkey), 64'(0));
                tick();
                rst_n = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    tick();
                    chk("idle_after_rst", 64'(ks.sub_valid), 64'(0));
                end
                return;
            end
            ks.sub_ready = !(r == stall_r && stalls < 5);
            if (!ks.sub_ready) stalls++;
            ks.start = (r == poke_r);
            ks.key_cd = (r == poke_r) ? ~k : k;
            ks.abort = (r == abort_r);
            tick();
            ks.start = 1'b0;
            ks.key_cd = k;
            if (r == abort_r) begin
                ks.abort = 1'b0;
                chk("abort_valid", 64'(ks.sub_valid), 64'(0));
                chk("abort_busy", 64'(ks.busy), 64'(0));
                chk("abort_round", 64'(ks.round), 64'(0));
                return;
            end
            if (ks.sub_ready) begin
                xfers++;
                r++;
            end
        end
        ks.sub_ready = 1'b1;
        chk("done_rounds", 64'(r), 64'(16));
        chk("xfers", 64'(xfers), 64'(16));
        chk("end_valid", 64'(ks.sub_valid), 64'(0));
        chk("end_busy", 64'(ks.busy), 64'(0));
        chk("end_cd", 64'(ks.sub_cd), 64'(exp_cd(k, 15, e)));
    endtask

    initial begin
        ks.start = 1'b0;
        ks.abort = 1'b0;
        ks.sub_ready = 1'b0;
        ks.key_cd = '0;
`ifdef DES_KS_ENC_MODE_EN
        ks.enc = 1'b0;
`endif
        key1 = {28'h0000001, 28'h0000001};
        key2 = pc1(64'h133457799BBCDFF1);
        #1;
        chk("reset_valid", 64'(ks.sub_valid), 64'(0));
        chk("reset_busy", 64'(ks.busy), 64'(0));
        chk("reset_last", 64'(ks.last), 64'(0));
        chk("reset_round", 64'(ks.round), 64'(0));
        chk("reset_cd", 64'(ks.sub_cd), 64'(0));
        chk("reset_subkey", 64'(ks.subkey), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_no_start", 64'(ks.sub_valid), 64'(0));
        run(key1, 1'b0, 16, 16, 16, 16);
        run(key2, 1'b0, 16, 16, 16, 16);
        run(key2, 1'b0, 3, 16, 16, 16);
        run(key2, 1'b0, 16, 6, 16, 16);
        run(key2, 1'b0, 16, 16, 9, 16);
        run(key1, 1'b0, 16, 16, 16, 16);
        run(key2, 1'b0, 16, 16, 16, 11);
        ks.key_cd = key2;
        ks.start = 1'b1;
        ks.abort = 1'b1;
        tick();
        ks.start = 1'b0;
        ks.abort = 1'b0;
        chk("start_abort_valid", 64'(ks.sub_valid), 64'(0));
        chk("start_abort_busy", 64'(ks.busy), 64'(0));
        chk("start_abort_cd", 64'(ks.sub_cd), 64'(0));
        tick();
        chk("start_abort_idle", 64'(ks.sub_valid), 64'(0));
        run(key1, 1'b0, 16, 16, 16, 16);
`ifdef DES_KS_ENC_MODE_EN
        run(key1, 1'b1, 16, 16, 16, 16);
        run(key2, 1'b1, 5, 16, 16, 16);
        run(key2, 1'b0, 16, 16, 16, 16);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
